// File: rtl/par_serializer_pkg.sv
// Shared types and length helpers for the parallel-to-serial converter.
// Optional build macro used by the top: PAR_SERIALIZER_PARITY_EN.
package par_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A zero length code means a full-width word.
  function automatic int eff_len(input int mod, input int data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

  function automatic bit len_legal(input int len, input int min_len);
    return (len >= min_len);
  endfunction

endpackage

// File: rtl/par_serializer_if.sv
// Parallel word handshake and serial bit-stream bundle of par_serializer.
// slave is the serializer's view, master is the producer/consumer side.
interface par_serializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              data_ready_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_last_o;
  logic              busy_o;

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output data_ready_o,
    output ser_data_o,
    output ser_data_val_o,
    output ser_last_o,
    output busy_o
  );

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  data_ready_o,
    input  ser_data_o,
    input  ser_data_val_o,
    input  ser_last_o,
    input  busy_o
  );

endinterface

// File: rtl/par_serializer_hold.sv
// One-entry holding register (word, length, valid) in front of the shifter.
// Only the valid flag is reset; payload is qualified by it.
module par_serializer_hold
  import par_serializer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [LEN_W-1:0]  push_len,
  input  logic              pop,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data,
  output logic [LEN_W-1:0]  hold_len,
  output logic              ready
);

  logic              valid_p1;
  logic [DATA_W-1:0] data_p1;
  logic [LEN_W-1:0]  len_p1;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_p1 <= 1'b0;
    end else begin
      valid_p1 <= push | (valid_p1 & ~pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_p1 <= push_data;
      len_p1  <= push_len;
    end
  end

  assign hold_valid = valid_p1;
  assign hold_data  = data_p1;
  assign hold_len   = len_p1;
  // Ready comes from stored state only, never from the incoming valid.
  assign ready      = ~valid_p1;

endmodule

// File: rtl/par_serializer.sv
// Parallel word to serial bit-stream converter with programmable length and a
// one-entry holding register. Define PAR_SERIALIZER_PARITY_EN for a trailing even-parity bit.
module par_serializer
  import par_serializer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_LEN   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  par_serializer_if.slave bus
);

  typedef logic [MOD_W:0]    len_t;
  typedef logic [MOD_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam len_t FULL_LEN = len_t'(DATA_W);

  state_t state, state_n;
  cnt_t   cnt_p1;
  word_t  sh_p1;

  logic  ready, hold_valid;
  word_t hold_data, ld_data;
  len_t  hold_len, in_len, ld_len;
  logic  accept, legal, free, last_cyc, from_hold, load, push;
  logic  shifting, cur_bit;

  // MSB-first moves the low len bits to the top so the first bit is data[len-1].
  function automatic word_t align(input word_t d, input len_t l);
    if (MSB_FIRST) begin
      return d << (FULL_LEN - l);
    end
    return d;
  endfunction

  function automatic word_t shift_one(input word_t d);
    if (MSB_FIRST) begin
      return d << 1;
    end
    return d >> 1;
  endfunction

  assign accept = bus.data_val_i & ready;
  assign in_len = len_t'(eff_len(int'(bus.data_mod_i), DATA_W));
  assign legal  = len_legal(int'(in_len), MIN_LEN);

`ifdef PAR_SERIALIZER_PARITY_EN
  logic par_phase_p1;
  logic par_acc_p1;
  assign last_cyc = par_phase_p1;
`else
  assign last_cyc = (cnt_p1 == '0);
`endif

  assign shifting  = (state == SHIFT);
  assign free      = (state == IDLE) | (shifting & last_cyc);
  assign from_hold = free & hold_valid;
  // Ready implies an empty holding register, so accept never collides with from_hold.
  assign load      = from_hold | (free & accept & legal);
  assign push      = accept & legal & ~(free & ~hold_valid);
  assign ld_data   = from_hold ? hold_data : bus.data_i;
  assign ld_len    = from_hold ? hold_len  : in_len;
  assign cur_bit   = MSB_FIRST ? sh_p1[DATA_W-1] : sh_p1[0];

  par_serializer_hold #(
    .DATA_W (DATA_W),
    .LEN_W  (MOD_W + 1)
  ) u_hold (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .push       (push),
    .push_data  (bus.data_i),
    .push_len   (in_len),
    .pop        (from_hold),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_len   (hold_len),
    .ready      (ready)
  );

  always_comb begin
    state_n = state;
    if (free) begin
      state_n = load ? SHIFT : IDLE;
    end
  end

  // Stage p1: control registers (state, bit counter, parity phase)
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state  <= IDLE;
      cnt_p1 <= '0;
`ifdef PAR_SERIALIZER_PARITY_EN
      par_phase_p1 <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (load) begin
        cnt_p1 <= cnt_t'(ld_len - 1'b1);
`ifdef PAR_SERIALIZER_PARITY_EN
        par_phase_p1 <= 1'b0;
      end else if (free) begin
        par_phase_p1 <= 1'b0;
      end else if (cnt_p1 == '0) begin
        par_phase_p1 <= 1'b1;
`endif
      end else if (shifting && cnt_p1 != '0) begin
        cnt_p1 <= cnt_p1 - 1'b1;
      end
    end
  end

  // Stage p1: shifter payload, qualified by state so it needs no reset
  always_ff @(posedge clk_i) begin
    if (load) begin
      sh_p1 <= align(ld_data, ld_len);
    end else if (shifting) begin
      sh_p1 <= shift_one(sh_p1);
    end
  end

`ifdef PAR_SERIALIZER_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (load) begin
      par_acc_p1 <= 1'b0;
    end else if (shifting && !par_phase_p1) begin
      par_acc_p1 <= par_acc_p1 ^ cur_bit;
    end
  end

  assign bus.ser_data_o = shifting & (par_phase_p1 ? par_acc_p1 : cur_bit);
  assign bus.ser_last_o = shifting & par_phase_p1;
`else
  assign bus.ser_data_o = shifting & cur_bit;
  assign bus.ser_last_o = shifting & (cnt_p1 == '0);
`endif

  assign bus.ser_data_val_o = shifting;
  assign bus.data_ready_o   = ready;
  assign bus.busy_o         = shifting | hold_valid;

endmodule

// File: tb/tb_par_serializer.sv
// Scoreboard bench for par_serializer: MSB-first and LSB-first instances,
// expected bits queued at each accepted handshake and checked per serial cycle.
module tb_par_serializer;

  localparam int DW = 16;
  localparam int MW = 4;
`ifdef PAR_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  int   total  = 0;
  int   bad    = 0;
  logic [1:0] mq[$];
  logic [1:0] lq[$];

  always #5 clk_i = ~clk_i;

  par_serializer_if #(.DATA_W(DW), .MOD_W(MW)) m_if ();
  par_serializer_if #(.DATA_W(DW), .MOD_W(MW)) l_if ();

  par_serializer #(.DATA_W(DW), .MOD_W(MW), .MIN_LEN(3), .MSB_FIRST(1'b1)) u_msb (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (m_if.slave)
  );

  par_serializer #(.DATA_W(DW), .MOD_W(MW), .MIN_LEN(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (l_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {bit, last} sequence for one accepted word.
  function automatic void model(input logic [15:0] d, input logic [3:0] m, input bit msb);
    int   len;
    logic b, l, p;
    len = (m == 0) ? 16 : int'(m);
    p   = 1'b0;
    if (len < 3) return;
    for (int i = 0; i < len; i++) begin
      b = msb ? d[len-1-i] : d[i];
      p = p ^ b;
      l = (i == len - 1) && (PB == 0);
      if (msb) mq.push_back({b, l});
      else     lq.push_back({b, l});
    end
    if (PB == 1) begin
      if (msb) mq.push_back({p, 1'b1});
      else     lq.push_back({p, 1'b1});
    end
  endfunction

  task automatic send_m(input logic [15:0] d, input logic [3:0] m);
    int n;
    n = 0;
    m_if.data_i     = d;
    m_if.data_mod_i = m;
    m_if.data_val_i = 1'b1;
    while (m_if.data_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("m_ready_timeout", 32'd0, 32'd1);
      m_if.data_val_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    model(d, m, 1'b1);
    #1;
    m_if.data_val_i = 1'b0;
  endtask

  task automatic send_l(input logic [15:0] d, input logic [3:0] m);
    int n;
    n = 0;
    l_if.data_i     = d;
    l_if.data_mod_i = m;
    l_if.data_val_i = 1'b1;
    while (l_if.data_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("l_ready_timeout", 32'd0, 32'd1);
      l_if.data_val_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    model(d, m, 1'b0);
    #1;
    l_if.data_val_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!arst_i) begin
      if (m_if.ser_data_val_o) begin
        if (mq.size() == 0) chk("m_unexpected_bit", 32'd1, 32'd0);
        else chk("m_bit_last", {m_if.ser_data_o, m_if.ser_last_o}, mq.pop_front());
      end else begin
        chk("m_idle_out", {m_if.ser_data_o, m_if.ser_last_o}, 32'd0);
      end
    end
  end

  always @(negedge clk_i) begin
    if (!arst_i) begin
      if (l_if.ser_data_val_o) begin
        if (lq.size() == 0) chk("l_unexpected_bit", 32'd1, 32'd0);
        else chk("l_bit_last", {l_if.ser_data_o, l_if.ser_last_o}, lq.pop_front());
      end else begin
        chk("l_idle_out", {l_if.ser_data_o, l_if.ser_last_o}, 32'd0);
      end
    end
  end

  initial begin
    int n;
    m_if.data_i = '0; m_if.data_mod_i = '0; m_if.data_val_i = 1'b0;
    l_if.data_i = '0; l_if.data_mod_i = '0; l_if.data_val_i = 1'b0;

    // reset state, before any clock edge
    #1;
    chk("rst_val",   m_if.ser_data_val_o, 32'd0);
    chk("rst_data",  m_if.ser_data_o,     32'd0);
    chk("rst_last",  m_if.ser_last_o,     32'd0);
    chk("rst_ready", m_if.data_ready_o,   32'd1);
    chk("rst_busy",  m_if.busy_o,         32'd0);
    #12;
    @(negedge clk_i);
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // full-width word, MSB first, one-cycle latency
    send_m(16'hA5C3, 4'd0);
    chk("t1_latency",   m_if.ser_data_val_o, 32'd1);
    chk("t1_first_bit", m_if.ser_data_o,     32'd1);
    chk("t1_busy_on",   m_if.busy_o,         32'd1);
    repeat (16 + PB) @(posedge clk_i);
    #1;
    chk("t1_busy_off", m_if.busy_o,         32'd0);
    chk("t1_val_off",  m_if.ser_data_val_o, 32'd0);

    // back-to-back short words through the holding register
    send_m(16'hFFFF, 4'd5);
    send_m(16'h0000, 4'd4);
    chk("t2_ready_full", m_if.data_ready_o, 32'd0);
    chk("t2_busy",       m_if.busy_o,       32'd1);
    n = 0;
    repeat (8 + 2 * PB) begin
      @(negedge clk_i);
      if (m_if.ser_data_val_o) n++;
    end
    chk("t2_continuous", n, 8 + 2 * PB);
    @(negedge clk_i);
    chk("t2_end_gap", m_if.ser_data_val_o, 32'd0);
    chk("t2_ready_back", m_if.data_ready_o, 32'd1);

    // illegal lengths are swallowed; minimum legal length still works
    send_m(16'hFFFF, 4'd1);
    chk("t3_busy_mod1", m_if.busy_o,         32'd0);
    chk("t3_val_mod1",  m_if.ser_data_val_o, 32'd0);
    send_m(16'hFFFF, 4'd2);
    chk("t3_busy_mod2", m_if.busy_o,         32'd0);
    chk("t3_val_mod2",  m_if.ser_data_val_o, 32'd0);
    send_m(16'hFFF5, 4'd3);
    chk("t3_val_mod3",  m_if.ser_data_val_o, 32'd1);
    repeat (4 + PB) @(posedge clk_i);
    #1;

    // reset at bit 7 with a held word pending
    send_m(16'h1234, 4'd0);
    send_m(16'hBEEF, 4'd0);
    repeat (6) @(posedge clk_i);
    #1;
    chk("t5_pre_busy", m_if.busy_o, 32'd1);
    arst_i = 1'b1;
    mq.delete();
    #1;
    chk("t5_rst_val",   m_if.ser_data_val_o, 32'd0);
    chk("t5_rst_data",  m_if.ser_data_o,     32'd0);
    chk("t5_rst_last",  m_if.ser_last_o,     32'd0);
    chk("t5_rst_ready", m_if.data_ready_o,   32'd1);
    chk("t5_rst_busy",  m_if.busy_o,         32'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send_m(16'hA5C3, 4'd0);
    chk("t5_latency", m_if.ser_data_val_o, 32'd1);
    repeat (16 + PB) @(posedge clk_i);
    #1;
    chk("t5_busy_off", m_if.busy_o, 32'd0);

    // LSB-first instance
    send_l(16'h0001, 4'd3);
    chk("t4_latency", l_if.ser_data_val_o, 32'd1);
    send_l(16'hA5C3, 4'd0);
    send_l(16'h8C00, 4'd12);

    n = 0;
    while ((mq.size() != 0 || lq.size() != 0) && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    chk("drain_m", mq.size(), 32'd0);
    chk("drain_l", lq.size(), 32'd0);
    chk("end_busy_l", l_if.busy_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
